isqrt_seq: RTL and testbench



---
 rtl/isqrt_seq.sv | 123 ++++++++++++
 tb/tb_isqrt_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock.
// Returns floor(sqrt(radicand)) and radicand - root^2 after N+1 clocks.
`timescale 1ns/1ps
module isqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   radicand,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   remainder,
    output logic [1:0]         dbg_state
);

    localparam int N  = WIDTH / 2;
    localparam int L  = N + 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] op;
    logic [L-1:0]     rem;
    logic [N-1:0]     root_p;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_iter;
    logic [L-1:0]     rem_sh;
    logic [L-1:0]     sub_b;
    logic [L-1:0]     gen;
    logic [L-1:0]     prop;
    logic [L-1:0]     gk;
    logic [L-1:0]     pk;
    logic [L-1:0]     carry;
    logic [L-1:0]     trial;
    logic             borrow;
    logic [L-1:0]     rem_nxt;
    logic [N-1:0]     root_nxt;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == CALC) && (cnt == '0);

    // The remainder never exceeds 2*root, so the top bits dropped by the shift are always zero.
    assign rem_sh = L'({rem, op[WIDTH-1 -: 2]});
    assign sub_b  = {root_p, 2'b01};

    // Trial subtract as a + ~b + 1 through a Kogge-Stone prefix of generate/propagate cells.
    always_comb begin
        gen   = rem_sh & ~sub_b;
        prop  = rem_sh ^ ~sub_b;
        gk    = gen;
        pk    = prop;
        gk[0] = gen[0] | prop[0];
        for (int d = 1; d < L; d = d * 2) begin
            for (int i = L - 1; i >= d; i--) begin
                gk[i] = gk[i] | (pk[i] & gk[i-d]);
                pk[i] = pk[i] & pk[i-d];
            end
        end
        carry    = {gk[L-2:0], 1'b1};
        trial    = prop ^ carry;
        borrow   = ~gk[L-1];
        rem_nxt  = borrow ? rem_sh : trial;
        root_nxt = {root_p[N-2:0], ~borrow};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op        <= '0;
            rem       <= '0;
            root_p    <= '0;
            cnt       <= '0;
            root      <= '0;
            remainder <= '0;
        end else if (accept) begin
            op     <= radicand;
            rem    <= '0;
            root_p <= '0;
            cnt    <= CW'(N - 1);
        end else if (state == CALC) begin
            op     <= op << 2;
            rem    <= rem_nxt;
            root_p <= root_nxt;
            cnt    <= cnt - CW'(1);
            if (last_iter) begin
                root      <= root_nxt;
                remainder <= rem_nxt[N:0];
            end
        end
    end

    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed bench for isqrt_seq (WIDTH=32): vectors, ignored start, back-to-back,
// and asynchronous reset in the middle of an iteration.
`timescale 1ns/1ps
module tb_isqrt_seq;

    localparam int WIDTH = 32;
    localparam int N     = WIDTH / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  radicand;
    logic              busy;
    logic              done;
    logic [N-1:0]      root;
    logic [N:0]        remainder;
    logic [1:0]        dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    isqrt_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .radicand  (radicand),
        .busy      (busy),
        .done      (done),
        .root      (root),
        .remainder (remainder),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch one operation and wait (bounded) for its done pulse.
    task automatic do_op(input logic [WIDTH-1:0] x, output logic [N-1:0] r,
                         output logic [N:0] m, output int lat, output int busy_cycles);
        lat = 0; busy_cycles = 0; r = '0; m = '0;
        @(negedge clk);
        start = 1'b1; radicand = x;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) begin start = 1'b0; radicand = $urandom; end
            if (busy) busy_cycles++;
            if (done) begin lat = i; r = root; m = remainder; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; radicand = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (root !== '0) $display("FAIL reset_root: got %0h expected 0", root); else pass_cnt++;
        total_cnt++; if (remainder !== '0) $display("FAIL reset_rem: got %0h expected 0", remainder); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else pass_cnt++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_after_reset_busy: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] xs [8];
        logic [N-1:0]     rs [8];
        logic [N:0]       ms [8];
        logic [N-1:0]     r;
        logic [N:0]       m;
        int               lat, bc;
        xs = '{32'd0, 32'd1, 32'd2, 32'd15, 32'd99, 32'd1000000, 32'h4000_0000, 32'hFFFF_FFFF};
        rs = '{16'd0, 16'd1, 16'd1, 16'd3,  16'd9,  16'd1000,    16'h8000,      16'hFFFF};
        ms = '{17'd0, 17'd0, 17'd1, 17'd6,  17'd18, 17'd0,       17'd0,         17'h1FFFE};
        for (int k = 0; k < 8; k++) begin
            do_op(xs[k], r, m, lat, bc);
            total_cnt++; if (lat != N + 1) $display("FAIL vec_latency[%0d]: got %0d expected %0d", k, lat, N + 1); else pass_cnt++;
            total_cnt++; if (bc != N) $display("FAIL vec_busy_cycles[%0d]: got %0d expected %0d", k, bc, N); else pass_cnt++;
            total_cnt++; if (r !== rs[k]) $display("FAIL vec_root[%0d]: got %0h expected %0h", k, r, rs[k]); else pass_cnt++;
            total_cnt++; if (m !== ms[k]) $display("FAIL vec_rem[%0d]: got %0h expected %0h", k, m, ms[k]); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (done !== 1'b0) $display("FAIL vec_done_pulse[%0d]: got %b expected 0", k, done); else pass_cnt++;
            total_cnt++; if (root !== rs[k]) $display("FAIL vec_root_hold[%0d]: got %0h expected %0h", k, root, rs[k]); else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        int first_busy = 0, last_busy = 0, busy_n = 0, done_n = 0, done_at = 0;
        logic [N-1:0] r = '0;
        logic [N:0]   m = '0;
        @(negedge clk);
        start = 1'b1; radicand = 32'd99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (busy) begin
                busy_n++;
                if (first_busy == 0) first_busy = i;
                last_busy = i;
            end
            if (done) begin done_n++; done_at = i; r = root; m = remainder; end
            start = (i == 3) || (i == 10);
            radicand = start ? 32'd16 : $urandom;
        end
        total_cnt++; if (done_n != 1) $display("FAIL ign_done_count: got %0d expected 1", done_n); else pass_cnt++;
        total_cnt++; if (done_at != N + 1) $display("FAIL ign_done_at: got %0d expected %0d", done_at, N + 1); else pass_cnt++;
        total_cnt++; if (r !== 16'd9) $display("FAIL ign_root: got %0d expected 9", r); else pass_cnt++;
        total_cnt++; if (m !== 17'd18) $display("FAIL ign_rem: got %0d expected 18", m); else pass_cnt++;
        total_cnt++; if (busy_n != N) $display("FAIL ign_busy_count: got %0d expected %0d", busy_n, N); else pass_cnt++;
        total_cnt++; if (first_busy != 1 || last_busy != N)
            $display("FAIL ign_busy_span: got %0d..%0d expected 1..%0d", first_busy, last_busy, N); else pass_cnt++;
        total_cnt++; if (root !== 16'd9 || remainder !== 17'd18)
            $display("FAIL ign_hold: got %0d/%0d expected 9/18", root, remainder); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int done_at [2] = '{0, 0};
        logic [N-1:0] r [2] = '{16'd0, 16'd0};
        logic [N:0]   m [2] = '{17'd0, 17'd0};
        logic [N-1:0] hold_r = '0;
        logic [N:0]   hold_m = '0;
        int done_n = 0, busy_low = 0;
        @(negedge clk);
        start = 1'b1; radicand = 32'd144;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) radicand = 32'd145;
            if (!busy) busy_low++;
            if (i == 20) begin hold_r = root; hold_m = remainder; end
            if (done) begin
                done_at[done_n] = i; r[done_n] = root; m[done_n] = remainder;
                done_n++;
                if (done_n == 2) begin start = 1'b0; break; end
            end
        end
        total_cnt++; if (done_n != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_n); else pass_cnt++;
        total_cnt++; if (done_at[0] != N + 1) $display("FAIL b2b_first_done: got %0d expected %0d", done_at[0], N + 1); else pass_cnt++;
        total_cnt++; if (done_at[1] - done_at[0] != N + 1)
            $display("FAIL b2b_spacing: got %0d expected %0d", done_at[1] - done_at[0], N + 1); else pass_cnt++;
        total_cnt++; if (r[0] !== 16'd12 || m[0] !== 17'd0) $display("FAIL b2b_res0: got %0d/%0d expected 12/0", r[0], m[0]); else pass_cnt++;
        total_cnt++; if (r[1] !== 16'd12 || m[1] !== 17'd1) $display("FAIL b2b_res1: got %0d/%0d expected 12/1", r[1], m[1]); else pass_cnt++;
        total_cnt++; if (hold_r !== 16'd12 || hold_m !== 17'd0)
            $display("FAIL b2b_hold_during_calc: got %0d/%0d expected 12/0", hold_r, hold_m); else pass_cnt++;
        total_cnt++; if (busy_low != 2) $display("FAIL b2b_busy_low: got %0d expected 2", busy_low); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_back_to_idle: got busy=%b done=%b expected 0/0", busy, done); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        int done_n = 0, busy_n = 0, lat, bc;
        logic [N-1:0] r;
        logic [N:0]   m;
        @(negedge clk);
        start = 1'b1; radicand = 32'hFFFF_FFFF;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        total_cnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else pass_cnt++;
        total_cnt++; if (root !== 16'd12) $display("FAIL rstmid_root_before: got %0d expected 12", root); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (root !== '0) $display("FAIL rstmid_root: got %0h expected 0", root); else pass_cnt++;
        total_cnt++; if (remainder !== '0) $display("FAIL rstmid_rem: got %0h expected 0", remainder); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rstmid_flags: got busy=%b done=%b expected 0/0", busy, done); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL rstmid_state: got %0d expected 0", dbg_state); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) done_n++;
            if (busy) busy_n++;
        end
        total_cnt++; if (done_n != 0 || busy_n != 0)
            $display("FAIL rstmid_stays_idle: got done=%0d busy=%0d expected 0/0", done_n, busy_n); else pass_cnt++;
        do_op(32'd4, r, m, lat, bc);
        total_cnt++; if (lat != N + 1) $display("FAIL rstmid_latency: got %0d expected %0d", lat, N + 1); else pass_cnt++;
        total_cnt++; if (r !== 16'd2 || m !== 17'd0) $display("FAIL rstmid_after: got %0d/%0d expected 2/0", r, m); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
